// File: rtl/mem_load_ctrl_if.sv
// Handshake and bus-strobe bundle between the control unit (master) and the
// memory-load sequencer (slave).
interface mem_load_ctrl_if #(
    parameter int SEL_W = 6
);
    logic             start;
    logic             MFC;
    logic [SEL_W-1:0] Ri;
    logic [SEL_W-1:0] Rj;

    logic R0_read, R1_read, R2_read, R3_read, P0_read;
    logic R0_write, R1_write, R2_write, R3_write, P0_write;
    logic MAR_write;
    logic MEM_EN;
    logic MEM_RW;
    logic MDR_mem_write;
    logic MDR_read;
    logic busy;
    logic done;
    logic err;

    modport master (
        output start, MFC, Ri, Rj,
        input  R0_read, R1_read, R2_read, R3_read, P0_read,
        input  R0_write, R1_write, R2_write, R3_write, P0_write,
        input  MAR_write, MEM_EN, MEM_RW, MDR_mem_write, MDR_read,
        input  busy, done, err
    );

    modport slave (
        input  start, MFC, Ri, Rj,
        output R0_read, R1_read, R2_read, R3_read, P0_read,
        output R0_write, R1_write, R2_write, R3_write, P0_write,
        output MAR_write, MEM_EN, MEM_RW, MDR_mem_write, MDR_read,
        output busy, done, err
    );
endinterface

// File: rtl/mem_load_ctrl.sv
// Memory-load sequencer: Ri <- MEM[Rj] over the shared bus, Moore outputs only.
// Optional MFC-wait timeout with abort pulse is enabled by defining LOAD_TIMEOUT_EN.
module mem_load_ctrl #(
    parameter int SEL_W          = 6
`ifdef LOAD_TIMEOUT_EN
    ,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic           clk,
    input  logic           reset,
    mem_load_ctrl_if.slave bus
);

`ifdef LOAD_TIMEOUT_EN
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_MEM, S_LATCH, S_WB, S_DONE, S_ERR
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_MEM, S_LATCH, S_WB, S_DONE
    } state_e;
`endif

    state_e           state_q, state_d;
    logic [SEL_W-1:0] ri_q, ri_d;
    logic [SEL_W-1:0] rj_q, rj_d;
    logic             mem_timeout;

`ifdef LOAD_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter restarts while in ADDR so every MEM visit begins at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_ADDR) begin
            cnt_d = '0;
        end else if (state_q == S_MEM && !bus.MFC) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mem_timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign mem_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ri_q    <= '0;
            rj_q    <= '0;
        end else begin
            state_q <= state_d;
            ri_q    <= ri_d;
            rj_q    <= rj_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ri_d    = ri_q;
        rj_d    = rj_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_ADDR;
                    ri_d    = bus.Ri;
                    rj_d    = bus.Rj;
                end
            end
            S_ADDR:  state_d = S_MEM;
            S_MEM: begin
                // MFC on the final count cycle still completes the load.
                if (bus.MFC) begin
                    state_d = S_LATCH;
                end else if (mem_timeout) begin
`ifdef LOAD_TIMEOUT_EN
                    state_d = S_ERR;
`else
                    state_d = S_MEM;
`endif
                end
            end
            S_LATCH: state_d = S_WB;
            S_WB:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
`ifdef LOAD_TIMEOUT_EN
            S_ERR:   state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    logic addr_ph, wb_ph;
    assign addr_ph = (state_q == S_ADDR);
    assign wb_ph   = (state_q == S_WB);

    // Select codes above 4 match no strobe, leaving the bus undriven or the data dropped.
    assign bus.R0_read  = addr_ph && (rj_q == SEL_W'(0));
    assign bus.R1_read  = addr_ph && (rj_q == SEL_W'(1));
    assign bus.R2_read  = addr_ph && (rj_q == SEL_W'(2));
    assign bus.R3_read  = addr_ph && (rj_q == SEL_W'(3));
    assign bus.P0_read  = addr_ph && (rj_q == SEL_W'(4));
    assign bus.R0_write = wb_ph && (ri_q == SEL_W'(0));
    assign bus.R1_write = wb_ph && (ri_q == SEL_W'(1));
    assign bus.R2_write = wb_ph && (ri_q == SEL_W'(2));
    assign bus.R3_write = wb_ph && (ri_q == SEL_W'(3));
    assign bus.P0_write = wb_ph && (ri_q == SEL_W'(4));

    assign bus.MAR_write     = addr_ph;
    assign bus.MEM_EN        = (state_q == S_MEM);
    assign bus.MEM_RW        = (state_q == S_MEM);
    assign bus.MDR_mem_write = (state_q == S_LATCH);
    assign bus.MDR_read      = wb_ph;
    assign bus.busy          = (state_q != S_IDLE);
`ifdef LOAD_TIMEOUT_EN
    assign bus.done          = (state_q == S_DONE) || (state_q == S_ERR);
    assign bus.err           = (state_q == S_ERR);
`else
    assign bus.done          = (state_q == S_DONE);
    assign bus.err           = 1'b0;
`endif

endmodule
